// File: rtl/trap_unit.sv
// Machine-mode trap/CSR responder: owns the M-mode CSR file, takes exceptions,
// interrupts and MRET from write-back, and redirects fetch with a flush handshake.
module trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_req_i,
    input  logic [2:0]  csr_funct3_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        retire_i,
    input  logic [31:0] next_pc_i,
    input  logic        mret_i,
    input  logic        xint_meip_i,
    input  logic        xint_mtip_i,
    input  logic        xint_msip_i,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ack_i
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_RW   = 2'd1;
    localparam logic [1:0] OP_RS   = 2'd2;
    localparam logic [1:0] OP_RC   = 2'd3;

    typedef enum logic {ST_IDLE, ST_REDIRECT} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]  w_sync;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_csr_old;
    logic [31:0] w_csr_new;
    logic [1:0]  w_op;
    logic        w_mapped;
    logic        w_read_only;
    logic        w_csr_wr;
    logic        w_csr_illegal;
    logic        w_idle;
    logic        w_exc;
    logic [31:0] w_int_active;
    logic        w_int_take;
    logic        w_trap_take;
    logic        w_mret_take;
    logic        w_csr_commit;
    logic [3:0]  w_int_code;
    logic [31:0] w_tvec_base;
    logic [31:0] w_trap_cause;
    logic [31:0] w_trap_tval;
    logic [31:0] w_trap_epc;
    logic [31:0] w_trap_target;
    logic [63:0] w_mcycle_inc;

    // Interrupt synchronizer, one 3-bit word per stage: {meip, mtip, msip}
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= {xint_meip_i, xint_mtip_i, xint_msip_i};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_mip     = {20'b0, w_sync[2], 3'b0, w_sync[1], 3'b0, w_sync[0], 3'b0};
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

    always_comb begin
        w_csr_old = '0;
        w_mapped  = 1'b1;
        case (csr_addr_i)
            A_MSTATUS:  w_csr_old = w_mstatus;
            A_MIE:      w_csr_old = r_mie;
            A_MTVEC:    w_csr_old = r_mtvec;
            A_MSCRATCH: w_csr_old = r_mscratch;
            A_MEPC:     w_csr_old = r_mepc;
            A_MCAUSE:   w_csr_old = r_mcause;
            A_MTVAL:    w_csr_old = r_mtval;
            A_MIP:      w_csr_old = w_mip;
            A_MCYCLE:   w_csr_old = r_mcycle[31:0];
            A_MCYCLEH:  w_csr_old = r_mcycle[63:32];
            A_MHARTID:  w_csr_old = '0;
            default:    w_mapped  = 1'b0;
        endcase
    end

    assign csr_rdata_o = w_csr_old;

    // Immediate forms differ only in where the operand came from
    always_comb begin
        w_op = OP_NONE;
        if (csr_req_i) begin
            case (csr_funct3_i)
                3'b001, 3'b101: w_op = OP_RW;
                3'b010, 3'b110: w_op = OP_RS;
                3'b011, 3'b111: w_op = OP_RC;
                default:        w_op = OP_NONE;
            endcase
        end
    end

    always_comb begin
        w_csr_new = w_csr_old;
        case (w_op)
            OP_RW:   w_csr_new = csr_wdata_i;
            OP_RS:   w_csr_new = w_csr_old | csr_wdata_i;
            OP_RC:   w_csr_new = w_csr_old & ~csr_wdata_i;
            default: w_csr_new = w_csr_old;
        endcase
    end

    assign w_read_only   = (csr_addr_i == A_MHARTID) || (csr_addr_i == A_MIP);
    assign w_csr_wr      = (w_op == OP_RW) || ((w_op != OP_NONE) && (csr_wdata_i != 32'd0));
    assign w_csr_illegal = (w_op != OP_NONE) && (!w_mapped || (w_read_only && w_csr_wr));

    assign w_idle       = (r_state == ST_IDLE);
    assign w_exc        = w_idle && (exc_valid_i || w_csr_illegal);
    assign w_int_active = r_mie & w_mip;
    assign w_int_take   = w_idle && !w_exc && retire_i && r_mstatus_mie && (w_int_active != 32'd0);
    assign w_trap_take  = w_exc || w_int_take;
    assign w_mret_take  = w_idle && !w_trap_take && mret_i;
    assign w_csr_commit = w_idle && !w_trap_take && w_csr_wr && !w_csr_illegal;

    always_comb begin
        if (w_int_active[11])     w_int_code = 4'd11;
        else if (w_int_active[3]) w_int_code = 4'd3;
        else                      w_int_code = 4'd7;
    end

    // A reported exception outranks a simultaneous illegal CSR access
    always_comb begin
        w_tvec_base = {r_mtvec[31:2], 2'b00};
        if (w_exc) begin
            w_trap_cause  = {28'b0, (exc_valid_i ? exc_cause_i : 4'd2)};
            w_trap_tval   = exc_valid_i ? exc_tval_i : 32'd0;
            w_trap_epc    = exc_pc_i;
            w_trap_target = w_tvec_base;
        end else begin
            w_trap_cause  = {1'b1, 27'b0, w_int_code};
            w_trap_tval   = 32'd0;
            w_trap_epc    = next_pc_i;
            w_trap_target = (r_mtvec[1:0] == 2'b01) ?
                            w_tvec_base + {26'b0, w_int_code, 2'b00} : w_tvec_base;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else begin
            if (w_csr_commit) begin
                case (csr_addr_i)
                    A_MSTATUS: begin
                        r_mstatus_mie  <= w_csr_new[3];
                        r_mstatus_mpie <= w_csr_new[7];
                    end
                    A_MIE:      r_mie      <= w_csr_new & 32'h0000_0888;
                    A_MTVEC:    r_mtvec    <= w_csr_new;
                    A_MSCRATCH: r_mscratch <= w_csr_new;
                    A_MEPC:     r_mepc     <= {w_csr_new[31:2], 2'b00};
                    A_MCAUSE:   r_mcause   <= w_csr_new;
                    A_MTVAL:    r_mtval    <= w_csr_new;
                    default: ;
                endcase
            end
            // Trap/MRET updates to mstatus come last so they win over a CSR write
            if (w_trap_take) begin
                r_mepc         <= {w_trap_epc[31:2], 2'b00};
                r_mcause       <= w_trap_cause;
                r_mtval        <= w_trap_tval;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (w_mret_take) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end
        end
    end

    assign w_mcycle_inc = r_mcycle + 64'd1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_mcycle <= '0;
        end else begin
            r_mcycle[31:0]  <= (w_csr_commit && csr_addr_i == A_MCYCLE)  ? w_csr_new : w_mcycle_inc[31:0];
            r_mcycle[63:32] <= (w_csr_commit && csr_addr_i == A_MCYCLEH) ? w_csr_new : w_mcycle_inc[63:32];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state       <= ST_IDLE;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_trap_take) begin
                r_redirect_pc <= w_trap_target;
            end else if (w_mret_take) begin
                r_redirect_pc <= r_mepc;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_trap_take || w_mret_take) w_state_next = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ack_i) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    assign flush_o       = (r_state == ST_REDIRECT);
    assign redirect_pc_o = r_redirect_pc;

endmodule

// File: tb/tb_trap_unit.sv
// Directed self-checking bench for trap_unit: CSR access, exceptions,
// vectored/prioritised interrupts, MRET, mcycle and reset during redirect.
module tb_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        retire;
    logic [31:0] next_pc;
    logic        mret;
    logic        meip, mtip, msip;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        ack;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trap_unit #(.MTVEC_RESET(32'h0000_0000), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .csr_req_i(csr_req), .csr_funct3_i(csr_funct3), .csr_addr_i(csr_addr),
        .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
        .exc_valid_i(exc_valid), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc), .exc_tval_i(exc_tval),
        .retire_i(retire), .next_pc_i(next_pc), .mret_i(mret),
        .xint_meip_i(meip), .xint_mtip_i(mtip), .xint_msip_i(msip),
        .flush_o(flush), .redirect_pc_o(redirect_pc), .redirect_ack_i(ack)
    );

    // Combinational read with no request asserted: no side effects.
    task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    // One-cycle CSR instruction; returns the old value seen in that cycle.
    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] wd, output logic [31:0] o);
        @(negedge clk);
        csr_req = 1'b1; csr_funct3 = f3; csr_addr = a; csr_wdata = wd;
        #1;
        o = csr_rdata;
        @(negedge clk);
        csr_req = 1'b0; csr_wdata = '0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [8];
        logic [31:0] exps  [8];
        logic [31:0] rd;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hF14};
        exps  = '{32'h1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", flush); end
        checks++;
        if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%08h exp=0", redirect_pc); end
        for (int i = 0; i < 8; i++) begin
            read_csr(addrs[i], rd);
            checks++;
            if (rd !== exps[i]) begin failures++; $display("FAIL reset_csr_%03h got=%08h exp=%08h", addrs[i], rd, exps[i]); end
        end
        @(negedge clk);
        rst = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_csr_access();
        logic [31:0] old, rd;
        csr_op(3'b001, 12'h305, 32'h100, old);
        checks++;
        if (old !== 32'h0) begin failures++; $display("FAIL mtvec_old got=%08h exp=0", old); end
        read_csr(12'h305, rd);
        checks++;
        if (rd !== 32'h100) begin failures++; $display("FAIL mtvec_new got=%08h exp=100", rd); end
        csr_op(3'b001, 12'h304, 32'hFFFF_FFFF, old);
        read_csr(12'h304, rd);
        checks++;
        if (rd !== 32'h888) begin failures++; $display("FAIL mie_mask got=%08h exp=888", rd); end
        csr_op(3'b001, 12'h304, 32'h0, old);
        csr_op(3'b001, 12'h300, 32'hFFFF_FFFF, old);
        read_csr(12'h300, rd);
        checks++;
        if (rd !== 32'h1888) begin failures++; $display("FAIL mstatus_mask got=%08h exp=1888", rd); end
        csr_op(3'b011, 12'h300, 32'h88, old);
        read_csr(12'h300, rd);
        checks++;
        if (rd !== 32'h1800) begin failures++; $display("FAIL mstatus_rc got=%08h exp=1800", rd); end
        csr_op(3'b101, 12'h341, 32'h103, old);
        read_csr(12'h341, rd);
        checks++;
        if (rd !== 32'h100) begin failures++; $display("FAIL mepc_align got=%08h exp=100", rd); end
        csr_op(3'b001, 12'h340, 32'h55, old);
        csr_op(3'b110, 12'h340, 32'hA0, old);
        csr_op(3'b011, 12'h340, 32'h05, old);
        read_csr(12'h340, rd);
        checks++;
        if (rd !== 32'hF0) begin failures++; $display("FAIL mscratch_rsrc got=%08h exp=f0", rd); end
        csr_op(3'b010, 12'h340, 32'h0, old);
        checks++;
        if (old !== 32'hF0) begin failures++; $display("FAIL mscratch_rs0 got=%08h exp=f0", old); end
        read_csr(12'h7C0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%08h exp=0", rd); end
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL csr_no_trap got=%0b exp=0", flush); end
        $display("csr_access: done");
    endtask

    task automatic test_exception();
        logic [31:0] rd;
        ack = 1'b0;
        @(negedge clk);
        exc_valid = 1'b1; exc_cause = 4'd4; exc_pc = 32'h80; exc_tval = 32'h123;
        @(negedge clk);
        exc_cause = 4'd6; exc_pc = 32'h900; exc_tval = 32'h999;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h100) begin
            failures++; $display("FAIL exc_redirect got=%0b/%08h exp=1/00000100", flush, redirect_pc);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (flush !== 1'b1 || redirect_pc !== 32'h100) begin
                failures++; $display("FAIL exc_hold%0d got=%0b/%08h exp=1/00000100", i, flush, redirect_pc);
            end
        end
        exc_valid = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL exc_release got=%0b exp=0", flush); end
        read_csr(12'h341, rd);
        checks++;
        if (rd !== 32'h80) begin failures++; $display("FAIL exc_mepc got=%08h exp=80", rd); end
        read_csr(12'h342, rd);
        checks++;
        if (rd !== 32'h4) begin failures++; $display("FAIL exc_mcause got=%08h exp=4", rd); end
        read_csr(12'h343, rd);
        checks++;
        if (rd !== 32'h123) begin failures++; $display("FAIL exc_mtval got=%08h exp=123", rd); end
        $display("exception: done");
    endtask

    task automatic test_vectored_int();
        logic [31:0] old, rd;
        csr_op(3'b001, 12'h305, 32'h201, old);
        csr_op(3'b001, 12'h300, 32'h8, old);
        csr_op(3'b001, 12'h304, 32'h800, old);
        @(negedge clk);
        meip = 1'b1;
        @(negedge clk);
        read_csr(12'h344, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL mip_early got=%08h exp=0", rd); end
        @(negedge clk);
        read_csr(12'h344, rd);
        checks++;
        if (rd !== 32'h800) begin failures++; $display("FAIL mip_sync got=%08h exp=800", rd); end
        retire = 1'b1; next_pc = 32'h44;
        @(negedge clk);
        retire = 1'b0;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h22C) begin
            failures++; $display("FAIL vint_redirect got=%0b/%08h exp=1/0000022c", flush, redirect_pc);
        end
        @(negedge clk);
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL vint_pulse got=%0b exp=0", flush); end
        read_csr(12'h342, rd);
        checks++;
        if (rd !== 32'h8000_000B) begin failures++; $display("FAIL vint_mcause got=%08h exp=8000000b", rd); end
        read_csr(12'h341, rd);
        checks++;
        if (rd !== 32'h44) begin failures++; $display("FAIL vint_mepc got=%08h exp=44", rd); end
        read_csr(12'h300, rd);
        checks++;
        if (rd !== 32'h1880) begin failures++; $display("FAIL vint_mstatus got=%08h exp=1880", rd); end
        $display("vectored_int: done");
    endtask

    task automatic test_priority_mret();
        logic [31:0] old, rd;
        mtip = 1'b1; msip = 1'b1;
        csr_op(3'b001, 12'h304, 32'h888, old);
        csr_op(3'b010, 12'h300, 32'h8, old);
        @(negedge clk);
        retire = 1'b1; next_pc = 32'h60;
        @(negedge clk);
        retire = 1'b0;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h22C) begin
            failures++; $display("FAIL prio_mei got=%0b/%08h exp=1/0000022c", flush, redirect_pc);
        end
        @(negedge clk);
        read_csr(12'h342, rd);
        checks++;
        if (rd !== 32'h8000_000B) begin failures++; $display("FAIL prio_mcause got=%08h exp=8000000b", rd); end
        read_csr(12'h341, rd);
        checks++;
        if (rd !== 32'h60) begin failures++; $display("FAIL prio_mepc got=%08h exp=60", rd); end
        @(negedge clk);
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h60) begin
            failures++; $display("FAIL mret_redirect got=%0b/%08h exp=1/00000060", flush, redirect_pc);
        end
        @(negedge clk);
        read_csr(12'h300, rd);
        checks++;
        if (rd !== 32'h1888) begin failures++; $display("FAIL mret_mstatus got=%08h exp=1888", rd); end
        meip = 1'b0;
        repeat (3) @(negedge clk);
        retire = 1'b1; next_pc = 32'h70;
        @(negedge clk);
        retire = 1'b0;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h20C) begin
            failures++; $display("FAIL prio_msi got=%0b/%08h exp=1/0000020c", flush, redirect_pc);
        end
        @(negedge clk);
        read_csr(12'h342, rd);
        checks++;
        if (rd !== 32'h8000_0003) begin failures++; $display("FAIL msi_mcause got=%08h exp=80000003", rd); end
        mtip = 1'b0; msip = 1'b0;
        csr_op(3'b001, 12'h304, 32'h0, old);
        $display("priority_mret: done");
    endtask

    task automatic test_illegal_csr();
        logic [31:0] old, rd;
        exc_pc = 32'h10;
        csr_op(3'b001, 12'hF14, 32'h5, old);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h200) begin
            failures++; $display("FAIL illegal_redirect got=%0b/%08h exp=1/00000200", flush, redirect_pc);
        end
        @(negedge clk);
        read_csr(12'h342, rd);
        checks++;
        if (rd !== 32'h2) begin failures++; $display("FAIL illegal_mcause got=%08h exp=2", rd); end
        read_csr(12'h341, rd);
        checks++;
        if (rd !== 32'h10) begin failures++; $display("FAIL illegal_mepc got=%08h exp=10", rd); end
        read_csr(12'h343, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL illegal_mtval got=%08h exp=0", rd); end
        read_csr(12'hF14, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL hartid_ro got=%08h exp=0", rd); end
        csr_op(3'b010, 12'hF14, 32'h0, old);
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL hartid_read_legal got=%0b exp=0", flush); end
        @(negedge clk);
        csr_req = 1'b1; csr_funct3 = 3'b001; csr_addr = 12'h340; csr_wdata = 32'hABCD;
        exc_valid = 1'b1; exc_cause = 4'd0; exc_pc = 32'h30; exc_tval = 32'h0;
        @(negedge clk);
        csr_req = 1'b0; csr_wdata = '0; exc_valid = 1'b0;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h200) begin
            failures++; $display("FAIL exc_csr_redirect got=%0b/%08h exp=1/00000200", flush, redirect_pc);
        end
        @(negedge clk);
        read_csr(12'h340, rd);
        checks++;
        if (rd !== 32'hF0) begin failures++; $display("FAIL exc_csr_suppress got=%08h exp=f0", rd); end
        read_csr(12'h341, rd);
        checks++;
        if (rd !== 32'h30) begin failures++; $display("FAIL exc_csr_mepc got=%08h exp=30", rd); end
        $display("illegal_csr: done");
    endtask

    task automatic test_mcycle();
        logic [31:0] old, a, b, h0, lo, hi;
        @(negedge clk);
        read_csr(12'hB00, a);
        @(negedge clk);
        read_csr(12'hB00, b);
        checks++;
        if (b !== a + 32'd1) begin failures++; $display("FAIL mcycle_step got=%08h exp=%08h", b, a + 32'd1); end
        read_csr(12'hB80, h0);
        csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF, old);
        read_csr(12'hB00, lo);
        read_csr(12'hB80, hi);
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== h0) begin
            failures++; $display("FAIL mcycle_write got=%08h_%08h exp=%08h_ffffffff", hi, lo, h0);
        end
        @(negedge clk);
        read_csr(12'hB00, lo);
        read_csr(12'hB80, hi);
        checks++;
        if (lo !== 32'h0 || hi !== h0 + 32'd1) begin
            failures++; $display("FAIL mcycle_carry got=%08h_%08h exp=%08h_00000000", hi, lo, h0 + 32'd1);
        end
        $display("mcycle: done");
    endtask

    task automatic test_reset_mid_redirect();
        logic [11:0] addrs [6];
        logic [31:0] exps  [6];
        logic [31:0] rd;
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00};
        exps  = '{32'h1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        ack = 1'b0;
        @(negedge clk);
        exc_valid = 1'b1; exc_cause = 4'd6; exc_pc = 32'h84; exc_tval = 32'h7;
        @(negedge clk);
        exc_valid = 1'b0;
        checks++;
        if (flush !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%0b exp=1", flush); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0) begin
            failures++; $display("FAIL rstmid_flush got=%0b/%08h exp=0/00000000", flush, redirect_pc);
        end
        for (int i = 0; i < 6; i++) begin
            read_csr(addrs[i], rd);
            checks++;
            if (rd !== exps[i]) begin failures++; $display("FAIL rstmid_csr_%03h got=%08h exp=%08h", addrs[i], rd, exps[i]); end
        end
        @(negedge clk);
        rst = 1'b1; ack = 1'b1;
        @(negedge clk);
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0b exp=0", flush); end
        $display("reset_mid_redirect: done");
    endtask

    initial begin
        rst = 1'b0; csr_req = 1'b0; csr_funct3 = 3'b000; csr_addr = '0; csr_wdata = '0;
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        retire = 1'b0; next_pc = '0; mret = 1'b0;
        meip = 1'b0; mtip = 1'b0; msip = 1'b0; ack = 1'b1;
        test_reset();
        test_csr_access();
        test_exception();
        test_vectored_int();
        test_priority_mret();
        test_illegal_csr();
        test_mcycle();
        test_reset_mid_redirect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
- Machine-mode trap/CSR responder at the far end of the write-back stage's trap and CSR interface.
- Owns the M-mode CSR file and services CSR read/modify/write requests.
- Accepts exception reports, samples external/timer/software interrupts, and executes MRET.
- Drives a flush plus redirect PC to fetch through a valid/ack handshake.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- SYNC_STAGES, 2, flop stages on each xint_* input (minimum 1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- csr_req_i  in  1  CSR instruction at WB this cycle
- csr_funct3_i  in  3  001 RW, 010 RS, 011 RC, 101/110/111 immediate forms
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  operand (rs1 value or zero-extended uimm)
- csr_rdata_o  out  32  old CSR value, combinational
- exc_valid_i  in  1  exception reported by WB
- exc_cause_i  in  4  exception code (0, 2, 4, 6)
- exc_pc_i  in  32  PC of the instruction at WB
- exc_tval_i  in  32  trap value
- retire_i  in  1  instruction at WB retires this cycle
- next_pc_i  in  32  PC following the retiring instruction
- mret_i  in  1  MRET at WB
- xint_meip_i, xint_mtip_i, xint_msip_i  in  1 each  asynchronous interrupt lines
- flush_o  out  1  pipeline flush / redirect valid
- redirect_pc_o  out  32  target PC
- redirect_ack_i  in  1  fetch accepted redirect

Behaviour:
- Reset (rst_i=0 at a clk_i edge):
  - FSM to IDLE; flush_o=0, redirect_pc_o=0.
  - mstatus=32'h0000_1800 (MPP=11, MIE=0, MPIE=0); mie=0; mtvec=MTVEC_RESET.
  - mepc, mcause, mtval, mscratch, mcycle all 0; synchronizer flops cleared.
  - Reset asserted mid-REDIRECT abandons the redirect immediately.
- CSR map:
  - mstatus 300: only MIE[3] and MPIE[7] writable; MPP reads 11.
  - mie 304: bits 3, 7, 11 writable.
  - mtvec 305.
  - mscratch 340.
  - mepc 341: bits [1:0] read 0.
  - mcause 342.
  - mtval 343.
  - mip 344: read-only, {MEIP[11], MTIP[7], MSIP[3]} from synchronized inputs.
  - mcycle B00 / mcycleh B80.
  - mhartid F14: reads 0, read-only.
- CSR access:
  - csr_rdata_o = current value. Unmapped address reads 0.
  - New value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
  - Write suppressed for RS/RC when wdata==0.
  - Write commits at the clock edge, and only in IDLE with no trap taken that cycle.
  - Illegal access: unmapped address, or write to F14 or 344 (RW, or RS/RC with nonzero wdata).
  - Illegal access is an internal exception: cause 2, tval 0, pc exc_pc_i.
- mcycle: 64-bit counter, increments every cycle. A CSR write to either half that cycle replaces the increment for that half.
- Event priority in IDLE, one per cycle:
  1. exception (exc_valid_i or illegal CSR)
  2. interrupt
  3. mret_i
  4. Lower-priority events that cycle are dropped.
- Interrupt taken when all hold:
  - retire_i=1;
  - mstatus.MIE=1;
  - (mie & mip) != 0.
  - Priority among interrupts: MEI (11) > MSI (3) > MTI (7).
- Trap entry, at the edge:
  - mepc = exc_pc_i (exception) or next_pc_i (interrupt).
  - mcause = {interrupt bit, 27'b0, code}.
  - mtval = exc_tval_i for exceptions, 0 for interrupts.
  - MPIE <= MIE; MIE <= 0.
  - FSM goes to REDIRECT.
- Redirect target:
  - Exceptions, or mtvec[1:0] != 01: {mtvec[31:2], 2'b00}.
  - Interrupts with mtvec[1:0] == 01: {mtvec[31:2], 2'b00} + 4*code.
- MRET, at the edge: MIE <= MPIE; MPIE <= 1; target = mepc; FSM goes to REDIRECT.
- REDIRECT state:
  - flush_o=1 and redirect_pc_o stable from the cycle after the event.
  - Held until the cycle in which redirect_ack_i=1, then back to IDLE with flush_o=0 next cycle.
  - Latency: event to flush_o is 1 cycle. With ack tied high, flush_o pulses exactly 1 cycle.
  - exc/int/mret/csr_req are ignored (no state change) while in REDIRECT.
- Interrupt visibility: xint_* appear in mip SYNC_STAGES cycles after assertion.

Test Plan:
- Trap vector write: reset with MTVEC_RESET=0; CSRRW 305 wdata=0x100 -> csr_rdata_o=0, next read of 305 = 0x100.
- Exception entry: exc_valid_i=1, cause 4, pc 0x80, tval 0x123 -> next cycle flush_o=1, redirect_pc_o=0x100. Hold ack low 3 cycles -> flush_o stays 1 and PC stable. mepc=0x80, mcause=4, mtval=0x123.
- Vectored interrupt: mtvec=0x201, mstatus=0x8, mie=0x800, meip=1, retire_i with next_pc 0x44 -> after sync, redirect to 0x22C. mcause=0x8000000B, mepc=0x44, mstatus.MIE=0, MPIE=1.
- Interrupt priority and return: meip+mtip+msip all set and enabled -> cause 11 taken. Then mret_i -> redirect to mepc, MIE=1.
- Illegal CSR: write to F14 with exc_pc_i=0x10 -> csr_illegal trap, mcause=2, mepc=0x10, F14 unchanged. Same-cycle exc_valid_i with a CSRRW to 340 -> mscratch unchanged.
- Counter and reset: mcycle counts 1 per cycle. Write B00=0xFFFFFFFF -> next cycle mcycleh increments. rst_i=0 during REDIRECT -> flush_o=0 next cycle, all CSRs at reset values.
